pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch front end of the five-stage MIPS pipeline. It owns the program counter, drives the instruction ROM request/acknowledge interface, and presents the fetched PC/instruction pair to the IF/ID pipeline register. It applies branch redirects from ID and flush redirects from the exception unit. It also raises a stall request to the stall controller while a ROM access is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- stall  input  6  stall vector from stall controller; only stall[0] (freeze PC) is used here.
- flush  input  1  exception flush request, single-cycle pulse.
- new_pc  input  32  flush target; valid when flush=1.
- branch_flag_i  input  1  ID-stage taken-branch/jump indication.
- branch_target_i  input  32  branch target; valid when branch_flag_i=1.
- rom_ce_o  output  1  ROM request (chip enable).
- rom_addr_o  output  32  ROM word address (byte address, low 2 bits always 0).
- rom_ack_i  input  1  ROM acknowledge; data valid in the same cycle.
- rom_data_i  input  32  ROM read data.
- if_pc_o  output  32  PC of the instruction presented to IF/ID.
- rom_inst_o  output  32  instruction presented to IF/ID (0 = nop when none valid).
- stallreq_if_o  output  1  fetch stall request to stall controller.

## Operation
- State machine states: IDLE, RUN, DRAIN.
  - IDLE: entered on reset. Outputs rom_ce_o=0, if_pc_o=0, rom_inst_o=0. Goes to RUN on the first edge after rst deasserts.
  - RUN: rom_ce_o=1, rom_addr_o=pc.
  - DRAIN: a flushed access is still outstanding. rom_ce_o=1 and rom_addr_o=old pc, both held. rom_data_i is discarded.
- ROM protocol:
  - Once rom_ce_o=1, rom_addr_o stays stable until a cycle with rom_ack_i=1. Requests are never withdrawn except by reset.
  - An ack in the same cycle as the request is legal, giving a zero-wait fetch.
- IF/ID outputs:
  - In RUN with rom_ack_i=1: if_pc_o=pc, rom_inst_o=rom_data_i (combinational).
  - In all other cases: both outputs 0.
- stallreq_if_o = (state==RUN) & ~rom_ack_i. It is 0 in IDLE and DRAIN.
- Next-PC priority, evaluated each edge in RUN:
  1. flush: if rom_ack_i=1, pc<=new_pc and stay in RUN. Otherwise latch new_pc into redirect register and go to DRAIN.
  2. stall[0]=1: pc holds. If branch_flag_i=1, capture branch_target_i into a pending-branch register (pend_valid<=1).
  3. rom_ack_i=1 and pend_valid=1: pc<=pend_target, pend_valid<=0.
  4. rom_ack_i=1 and branch_flag_i=1: pc<=branch_target_i.
  5. rom_ack_i=1: pc<=pc+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
  6. Otherwise pc holds.
- DRAIN: on rom_ack_i=1, pc<=redirect register and return to RUN.
- flush clears pend_valid in every state. A flush during DRAIN overwrites the redirect register; the last flush wins.
- A branch is accepted even when rom_ack_i=0 and stall[0]=0. In that case it is captured as pending, so no redirect is lost.
- Reset asserted mid-access: all state resets immediately and rom_ce_o drops in the same cycle. The outstanding ROM access is abandoned.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, pend_valid=0, redirect=0.
- Output reset values: rom_ce_o=0, rom_addr_o=0, if_pc_o=0, rom_inst_o=0, stallreq_if_o=0.
- First request: rom_ce_o=1 with rom_addr_o=RESET_PC in the first cycle after rst rises (after one clk edge).
- Throughput with zero-wait ROM and no stall: one instruction per cycle. PC sequence is RESET_PC, +4, +8, ...
- A fetch with N wait cycles asserts stallreq_if_o for exactly N cycles. The PC advances on the ack edge.
- Branch redirect: branch seen at edge E puts the target on rom_addr_o in the cycle after E, or after the in-flight ack if one is pending.
- Flush with no outstanding access: new_pc is on rom_addr_o in the next cycle.
- Flush with an outstanding access: new_pc is on rom_addr_o in the cycle after the drain ack.

## Test plan
- Reset release, zero-wait ROM → rom_addr_o reads 0x0, 0x4, 0x8, 0xC on consecutive cycles. if_pc_o tracks it. stallreq_if_o stays 0.
- ROM acks after 3 wait cycles at pc=0x10 → stallreq_if_o high for exactly 3 cycles. rom_addr_o stable at 0x10. Next address is 0x14.
- stall[0]=1 for 2 cycles with branch_flag_i=1, target 0x200, in the first of them → pc holds. The first fetch after stall release is 0x200.
- flush=1, new_pc=0x180, while an access at 0x40 is waiting 2 more cycles → DRAIN with rom_addr_o=0x40. if_pc_o and rom_inst_o are 0 and stallreq_if_o=0 during DRAIN. rom_addr_o=0x180 in the cycle after the ack. A pending branch set before the flush is discarded.
- rst driven low mid-wait at pc=0x80 → rom_ce_o and all outputs go to 0 without a clock edge. After release, the fetch restarts at RESET_PC.
- pc=0xFFFF_FFFC with ack → next rom_addr_o=0x0000_0000.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Instruction ROM request/acknowledge bus between the fetch unit and the ROM.
interface pc_fetch_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;

  modport master (
    output rom_ce_o,
    output rom_addr_o,
    input  rom_ack_i,
    input  rom_data_i
  );

  modport slave (
    input  rom_ce_o,
    input  rom_addr_o,
    output rom_ack_i,
    output rom_data_i
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, runs the ROM handshake and feeds IF/ID.
// Branches that cannot be applied yet are held as pending; a flush that hits an
// outstanding ROM access waits in StDrain for that access to retire.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [31:0]       new_pc,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_i,
  pc_fetch_if.master        rom_if,
  output logic [31:0]       if_pc_o,
  output logic [31:0]       rom_inst_o,
  output logic              stallreq_if_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] redirect_q, redirect_d;

  // Only the PC-freeze bit of the stall vector matters to fetch.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // State registers; reset abandons any outstanding ROM access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      redirect_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      redirect_q    <= redirect_d;
    end
  end

  // Next-state and next-PC selection, flush highest priority.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    redirect_d    = redirect_q;
    if (flush) pend_valid_d = 1'b0;

    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (flush) begin
          if (rom_if.rom_ack_i) begin
            pc_d = new_pc;
          end else begin
            // Address must stay stable until the in-flight access is acked.
            redirect_d = new_pc;
            state_d    = StDrain;
          end
        end else if (stall[0]) begin
          if (branch_flag_i) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target_i;
          end
        end else if (rom_if.rom_ack_i && pend_valid_q) begin
          pc_d         = pend_target_q;
          pend_valid_d = 1'b0;
        end else if (rom_if.rom_ack_i && branch_flag_i) begin
          pc_d = branch_target_i;
        end else if (rom_if.rom_ack_i) begin
          pc_d = pc_q + 32'd4;
        end else if (branch_flag_i) begin
          // Access still waiting: remember the branch for the ack edge.
          pend_valid_d  = 1'b1;
          pend_target_d = branch_target_i;
        end
      end
      StDrain: begin
        if (flush) redirect_d = new_pc;
        if (rom_if.rom_ack_i) begin
          pc_d    = flush ? new_pc : redirect_q;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ROM request and IF/ID outputs; drained data never reaches IF/ID.
  always_comb begin
    rom_if.rom_ce_o   = 1'b0;
    rom_if.rom_addr_o = 32'h0;
    if_pc_o           = 32'h0;
    rom_inst_o        = 32'h0;
    stallreq_if_o     = 1'b0;
    unique case (state_q)
      StRun: begin
        rom_if.rom_ce_o   = 1'b1;
        rom_if.rom_addr_o = pc_q;
        stallreq_if_o     = ~rom_if.rom_ack_i;
        if (rom_if.rom_ack_i) begin
          if_pc_o    = pc_q;
          rom_inst_o = rom_if.rom_data_i;
        end
      end
      StDrain: begin
        rom_if.rom_ce_o   = 1'b1;
        rom_if.rom_addr_o = pc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: each task drives one scenario and checks the
// packed output bundle {rom_ce, rom_addr, if_pc, rom_inst, stallreq} inline.
module tb_pc_fetch;
  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_pc_o;
  logic [31:0] rom_inst_o;
  logic        stallreq_if_o;

  int checks;
  int failures;

  pc_fetch_if rom_if ();

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_if          (rom_if.master),
    .if_pc_o         (if_pc_o),
    .rom_inst_o      (rom_inst_o),
    .stallreq_if_o   (stallreq_if_o)
  );

  logic [97:0] obs;
  assign obs = {rom_if.rom_ce_o, rom_if.rom_addr_o, if_pc_o, rom_inst_o, stallreq_if_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next cycle on the falling edge.
  task automatic drive(input logic ack, input logic [31:0] data, input logic st0,
                       input logic br, input logic [31:0] tgt, input logic fl,
                       input logic [31:0] npc);
    @(negedge clk);
    rom_if.rom_ack_i  = ack;
    rom_if.rom_data_i = data;
    stall             = {5'b0, st0};
    branch_flag_i     = br;
    branch_target_i   = tgt;
    flush             = fl;
    new_pc            = npc;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, {1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      failures++; $display("FAIL idle_after_release got=%h exp=%h", obs, {1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
    end
  endtask

  task automatic test_zero_wait;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'(i * 4);
      d = 32'h1000_0000 + a;
      drive(1'b1, d, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (obs !== {1'b1, a, a, d, 1'b0}) begin
        failures++; $display("FAIL zero_wait_%0d got=%h exp=%h", i, obs, {1'b1, a, a, d, 1'b0});
      end
    end
  endtask

  task automatic test_wait_states;
    int sr_cycles;
    sr_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      if (stallreq_if_o === 1'b1) sr_cycles++;
      checks++;
      if (obs !== {1'b1, 32'h10, 32'h0, 32'h0, 1'b1}) begin
        failures++; $display("FAIL wait_%0d got=%h exp=%h", i, obs, {1'b1, 32'h10, 32'h0, 32'h0, 1'b1});
      end
    end
    drive(1'b1, 32'hAAAA_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    if (stallreq_if_o === 1'b1) sr_cycles++;
    checks++;
    if (obs !== {1'b1, 32'h10, 32'h10, 32'hAAAA_0010, 1'b0}) begin
      failures++; $display("FAIL wait_ack got=%h exp=%h", obs, {1'b1, 32'h10, 32'h10, 32'hAAAA_0010, 1'b0});
    end
    checks++;
    if (sr_cycles !== 3) begin
      failures++; $display("FAIL wait_stallreq_cycles got=%0d exp=3", sr_cycles);
    end
    drive(1'b1, 32'hAAAA_0014, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h14, 32'h14, 32'hAAAA_0014, 1'b0}) begin
      failures++; $display("FAIL wait_next got=%h exp=%h", obs, {1'b1, 32'h14, 32'h14, 32'hAAAA_0014, 1'b0});
    end
  endtask

  task automatic test_stall_branch;
    // pc = 0x18; branch captured while frozen, applied on the ack after release.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h18, 32'h0, 32'h0, 1'b1}) begin
      failures++; $display("FAIL stall_hold got=%h exp=%h", obs, {1'b1, 32'h18, 32'h0, 32'h0, 1'b1});
    end
    drive(1'b1, 32'h5555_0018, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h18, 32'h18, 32'h5555_0018, 1'b0}) begin
      failures++; $display("FAIL stall_release got=%h exp=%h", obs, {1'b1, 32'h18, 32'h18, 32'h5555_0018, 1'b0});
    end
    drive(1'b1, 32'h5555_0200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h200, 32'h200, 32'h5555_0200, 1'b0}) begin
      failures++; $display("FAIL stall_branch_target got=%h exp=%h", obs, {1'b1, 32'h200, 32'h200, 32'h5555_0200, 1'b0});
    end
  endtask

  task automatic test_flush_drain;
    // pc = 0x204: flush with ack, no outstanding access -> 0x40 next cycle.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h40, 32'h0, 32'h0, 1'b1}) begin
      failures++; $display("FAIL flush_nowait got=%h exp=%h", obs, {1'b1, 32'h40, 32'h0, 32'h0, 1'b1});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h180);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h40, 32'h0, 32'h0, 1'b0}) begin
      failures++; $display("FAIL drain_wait got=%h exp=%h", obs, {1'b1, 32'h40, 32'h0, 32'h0, 1'b0});
    end
    drive(1'b1, 32'hBAD0_0040, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h40, 32'h0, 32'h0, 1'b0}) begin
      failures++; $display("FAIL drain_ack got=%h exp=%h", obs, {1'b1, 32'h40, 32'h0, 32'h0, 1'b0});
    end
    drive(1'b1, 32'h6666_0180, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h180, 32'h180, 32'h6666_0180, 1'b0}) begin
      failures++; $display("FAIL drain_redirect got=%h exp=%h", obs, {1'b1, 32'h180, 32'h180, 32'h6666_0180, 1'b0});
    end
    // Pending branch to 0x300 must have been dropped by the flush.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h184, 32'h0, 32'h0, 1'b1}) begin
      failures++; $display("FAIL flush_drops_pending got=%h exp=%h", obs, {1'b1, 32'h184, 32'h0, 32'h0, 1'b1});
    end
  endtask

  task automatic test_reset_mid_access;
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h80, 32'h0, 32'h0, 1'b1}) begin
      failures++; $display("FAIL pre_reset_wait got=%h exp=%h", obs, {1'b1, 32'h80, 32'h0, 32'h0, 1'b1});
    end
    #1;
    rst = 1'b0;
    rom_if.rom_ack_i  = 1'b1;
    rom_if.rom_data_i = 32'h7777_0080;
    #1;
    checks++;
    if (obs !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", obs, {1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h8888_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h0, 32'h0, 32'h8888_0000, 1'b0}) begin
      failures++; $display("FAIL restart_pc got=%h exp=%h", obs, {1'b1, 32'h0, 32'h0, 32'h8888_0000, 1'b0});
    end
    drive(1'b1, 32'h8888_0004, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h4, 32'h4, 32'h8888_0004, 1'b0}) begin
      failures++; $display("FAIL restart_next got=%h exp=%h", obs, {1'b1, 32'h4, 32'h4, 32'h8888_0004, 1'b0});
    end
  endtask

  task automatic test_wrap;
    // pc = 0x8; redirect straight to the top word, then let it wrap.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 32'h9999_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h9999_FFFC, 1'b0}) begin
      failures++; $display("FAIL wrap_top got=%h exp=%h", obs, {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h9999_FFFC, 1'b0});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (obs !== {1'b1, 32'h0, 32'h0, 32'h0, 1'b1}) begin
      failures++; $display("FAIL wrap_zero got=%h exp=%h", obs, {1'b1, 32'h0, 32'h0, 32'h0, 1'b1});
    end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rst               = 1'b0;
    stall             = 6'b0;
    flush             = 1'b0;
    new_pc            = 32'h0;
    branch_flag_i     = 1'b0;
    branch_target_i   = 32'h0;
    rom_if.rom_ack_i  = 1'b0;
    rom_if.rom_data_i = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_branch();
    test_flush_drain();
    test_reset_mid_access();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
